// File: rtl/aes128_round_ops_pkg.sv
// Shared AES-128 definitions: modes, sequencer states, S-box/Rcon tables and GF(2^8) helpers.
package aes128_round_ops_pkg;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } mode_t;

  typedef enum logic {
    MC_IDLE,
    MC_RUN
  } mc_state_t;

  typedef enum logic {
    KS_IDLE,
    KS_SUB
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for the key produced by round 1..10; other indices yield 0.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      r[8*i +: 8] = x[8*(15-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes128_key_sched.sv
// AES-128 round-key generator: one round per request, SubWord through a single shared S-box.
module aes128_key_sched
  import aes128_round_ops_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_i,
  input  logic         key_start_i,
  input  logic         key_req_i,
  output logic [127:0] key_o,
  output logic         key_valid_o,
  output logic [3:0]   key_round_o
);

  ks_state_t    state_q;
  logic [127:0] key_q;    // big-endian: word 0 at [127:96]
  logic [3:0]   round_q;
  logic [1:0]   cnt_q;
  logic [23:0]  sub_q;
  logic         valid_q;

  logic [31:0]  rot_w;
  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [31:0]  temp_w;
  logic [127:0] next_key;

  assign rot_w = {key_q[23:0], key_q[31:24]};

  always_comb begin
    case (cnt_q)
      2'd0:    sbox_in = rot_w[31:24];
      2'd1:    sbox_in = rot_w[23:16];
      2'd2:    sbox_in = rot_w[15:8];
      default: sbox_in = rot_w[7:0];
    endcase
  end

  assign sbox_out = sbox(sbox_in);

  // Last SubWord byte comes straight from the S-box so the key lands on the fourth step.
  always_comb begin
    temp_w           = {sub_q, sbox_out} ^ {rcon(4'(round_q + 4'd1)), 24'h0};
    next_key[127:96] = key_q[127:96] ^ temp_w;
    next_key[95:64]  = key_q[95:64]  ^ next_key[127:96];
    next_key[63:32]  = key_q[63:32]  ^ next_key[95:64];
    next_key[31:0]   = key_q[31:0]   ^ next_key[63:32];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= KS_IDLE;
      key_q   <= '0;
      round_q <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (key_start_i) begin
        state_q <= KS_IDLE;
        key_q   <= key_i;
        round_q <= '0;
        cnt_q   <= '0;
        valid_q <= 1'b1;
      end else begin
        case (state_q)
          KS_IDLE: begin
            if (key_req_i && (round_q != 4'd10)) begin
              state_q <= KS_SUB;
              cnt_q   <= '0;
            end
          end
          KS_SUB: begin
            if (cnt_q != 2'd3) begin
              sub_q <= {sub_q[15:0], sbox_out};
              cnt_q <= 2'(cnt_q + 2'd1);
            end else begin
              key_q   <= next_key;
              round_q <= 4'(round_q + 4'd1);
              valid_q <= 1'b1;
              state_q <= KS_IDLE;
            end
          end
          default: state_q <= KS_IDLE;
        endcase
      end
    end
  end

  assign key_o       = byte_rev(key_q);
  assign key_valid_o = valid_q;
  assign key_round_o = round_q;

endmodule

// File: rtl/aes128_round_ops.sv
// AES-128 round helpers: combinational ShiftRows, byte-serial (Inv)MixColumns and the key schedule.
module aes128_round_ops
  import aes128_round_ops_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] state_i,
  output logic [127:0] shift_rows_o,
  input  logic         mc_start_i,
  input  logic         mc_mode_i,
  output logic [7:0]   mc_data_o,
  output logic [3:0]   mc_addr_o,
  output logic         mc_valid_o,
  output logic         mc_done_o,
  input  logic [127:0] key_i,
  input  logic         key_start_i,
  input  logic         key_req_i,
  output logic [127:0] key_o,
  output logic         key_valid_o,
  output logic [3:0]   key_round_o
);

  // Output byte n is row n%4 of column n/4; rows use the rotated coefficient set.
  function automatic logic [7:0] mix_byte(input logic [127:0] st, input mode_t m,
                                          input logic [3:0] n);
    logic [7:0] acc;
    logic [1:0] ci;
    logic [3:0] bi;
    logic [7:0] coef;
    acc = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      ci = 2'(k) - n[1:0];
      bi = {n[3:2], 2'(k)};
      if (m == ENCRYPT) begin
        case (ci)
          2'd0:    coef = 8'h02;
          2'd1:    coef = 8'h03;
          default: coef = 8'h01;
        endcase
      end else begin
        case (ci)
          2'd0:    coef = 8'h0e;
          2'd1:    coef = 8'h0b;
          2'd2:    coef = 8'h0d;
          default: coef = 8'h09;
        endcase
      end
      acc = acc ^ gf_mul(st[{bi, 3'b000} +: 8], coef);
    end
    return acc;
  endfunction

  always_comb begin
    shift_rows_o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shift_rows_o[8*(4*c + r) +: 8] = state_i[8*(4*((c + r) % 4) + r) +: 8];
      end
    end
  end

  mc_state_t    mc_state_q;
  logic [127:0] snap_q;
  mode_t        mode_q;
  logic [7:0]   data_q;
  logic [3:0]   addr_q;
  logic         valid_q;
  logic         done_q;

  logic [127:0] mix_src;
  mode_t        mix_mode;
  logic [3:0]   mix_idx;
  logic [7:0]   mix_out;

  // One mixer serves both the start cycle (live input) and the following bytes (snapshot).
  always_comb begin
    if (mc_start_i) begin
      mix_src  = state_i;
      mix_mode = mode_t'(mc_mode_i);
      mix_idx  = '0;
    end else begin
      mix_src  = snap_q;
      mix_mode = mode_q;
      mix_idx  = 4'(addr_q + 4'd1);
    end
    mix_out = mix_byte(mix_src, mix_mode, mix_idx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mc_state_q <= MC_IDLE;
      snap_q     <= '0;
      mode_q     <= ENCRYPT;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else if (mc_start_i) begin
      mc_state_q <= MC_RUN;
      snap_q     <= state_i;
      mode_q     <= mode_t'(mc_mode_i);
      data_q     <= mix_out;
      addr_q     <= '0;
      valid_q    <= 1'b1;
      done_q     <= 1'b0;
    end else if (mc_state_q == MC_RUN) begin
      if (addr_q == 4'd15) begin
        mc_state_q <= MC_IDLE;
        data_q     <= '0;
        addr_q     <= '0;
        valid_q    <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        data_q  <= mix_out;
        addr_q  <= mix_idx;
        valid_q <= 1'b1;
        done_q  <= (mix_idx == 4'd15);
      end
    end
  end

  assign mc_data_o  = data_q;
  assign mc_addr_o  = addr_q;
  assign mc_valid_o = valid_q;
  assign mc_done_o  = done_q;

  aes128_key_sched u_key_sched (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_i       (key_i),
    .key_start_i (key_start_i),
    .key_req_i   (key_req_i),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_round_o (key_round_o)
  );

endmodule

// File: tb/tb_aes128_round_ops.sv
// Directed self-checking bench for aes128_round_ops using FIPS-197 vectors.
module tb_aes128_round_ops;

  logic         clk;
  logic         rst;
  logic [127:0] state_in;
  logic [127:0] shift_rows;
  logic         mc_start;
  logic         mc_mode;
  logic [7:0]   mc_data;
  logic [3:0]   mc_addr;
  logic         mc_valid;
  logic         mc_done;
  logic [127:0] key_in;
  logic         key_start;
  logic         key_req;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   key_round;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] SR_IN    = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SR_EXP   = 128'h0b06010c07020d08030e09040f0a0500;
  localparam logic [127:0] ENC_IN   = {4{32'h455313db}};
  localparam logic [127:0] DEC_IN   = {4{32'hbca14d8e}};
  localparam logic [31:0]  ENC_COL  = 32'hbca14d8e;
  localparam logic [31:0]  DEC_COL  = 32'h455313db;
  localparam logic [127:0] KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_BE   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_BE  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes128_round_ops dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .state_i      (state_in),
    .shift_rows_o (shift_rows),
    .mc_start_i   (mc_start),
    .mc_mode_i    (mc_mode),
    .mc_data_o    (mc_data),
    .mc_addr_o    (mc_addr),
    .mc_valid_o   (mc_valid),
    .mc_done_o    (mc_done),
    .key_i        (key_in),
    .key_start_i  (key_start),
    .key_req_i    (key_req),
    .key_o        (key_out),
    .key_valid_o  (key_valid),
    .key_round_o  (key_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rev_bytes(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mc_valid"}, 128'(mc_valid), 128'd0);
    chk({tag, "_mc_done"}, 128'(mc_done), 128'd0);
    chk({tag, "_mc_data"}, 128'(mc_data), 128'd0);
    chk({tag, "_mc_addr"}, 128'(mc_addr), 128'd0);
    chk({tag, "_key_valid"}, 128'(key_valid), 128'd0);
    chk({tag, "_key_round"}, 128'(key_round), 128'd0);
    chk({tag, "_key_o"}, key_out, 128'd0);
  endtask

  // Called in cycle t+1 after a start; checks the 16 strobes and the idle cycle after them.
  task automatic mc_expect(input string tag, input logic [31:0] col);
    for (int n = 0; n < 16; n++) begin
      chk({tag, "_valid"}, 128'(mc_valid), 128'd1);
      chk({tag, "_addr"}, 128'(mc_addr), 128'(n));
      chk({tag, "_data"}, 128'(mc_data), 128'(col[8*(n%4) +: 8]));
      chk({tag, "_done"}, 128'(mc_done), (n == 15) ? 128'd1 : 128'd0);
      tick();
    end
    chk({tag, "_end_valid"}, 128'(mc_valid), 128'd0);
    chk({tag, "_end_done"}, 128'(mc_done), 128'd0);
    chk({tag, "_end_data"}, 128'(mc_data), 128'd0);
    chk({tag, "_end_addr"}, 128'(mc_addr), 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    state_in  = SR_IN;
    mc_start  = 1'b0;
    mc_mode   = 1'b0;
    key_in    = '0;
    key_start = 1'b0;
    key_req   = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    chk("shift_rows_in_reset", shift_rows, SR_EXP);
    rst = 1'b0;
    tick();
    chk("shift_rows", shift_rows, SR_EXP);

    // Key load and ten rounds, with one request issued while busy in round 3.
    key_in    = KEY;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    chk("key0_valid", 128'(key_valid), 128'd1);
    chk("key0_round", 128'(key_round), 128'd0);
    chk("key0_value", key_out, rev_bytes(KEY));
    tick();
    chk("key0_pulse", 128'(key_valid), 128'd0);
    chk("key0_hold", key_out, rev_bytes(KEY));
    for (int r = 1; r <= 10; r++) begin
      key_req = 1'b1;
      tick();
      key_req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        chk("key_busy_valid", 128'(key_valid), 128'd0);
        chk("key_busy_round", 128'(key_round), 128'(r - 1));
        if (r == 3 && k == 1) key_req = 1'b1;
        tick();
        key_req = 1'b0;
      end
      chk("key_strobe", 128'(key_valid), 128'd1);
      chk("key_round", 128'(key_round), 128'(r));
      if (r == 1)  chk("key_round1", key_out, rev_bytes(RK1_BE));
      if (r == 10) chk("key_round10", key_out, rev_bytes(RK10_BE));
      tick();
      chk("key_strobe_pulse", 128'(key_valid), 128'd0);
      chk("key_round_hold", 128'(key_round), 128'(r));
      if (r == 1)  chk("key_round1_hold", key_out, rev_bytes(RK1_BE));
    end
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("key_11th_no_strobe", 128'(key_valid), 128'd0);
      tick();
    end
    chk("key_11th_round", 128'(key_round), 128'd10);
    chk("key_11th_value", key_out, rev_bytes(RK10_BE));

    // Encrypt MixColumns; the input changes right after start and must be ignored.
    chk("mc_idle_valid", 128'(mc_valid), 128'd0);
    state_in = ENC_IN;
    mc_mode  = 1'b0;
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    state_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    mc_mode  = 1'b1;
    mc_expect("mc_enc", ENC_COL);

    // Abort an encrypt run at byte 2 with a decrypt start.
    state_in = ENC_IN;
    mc_mode  = 1'b0;
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    tick();
    tick();
    chk("mc_abort_pre_addr", 128'(mc_addr), 128'd2);
    state_in = DEC_IN;
    mc_mode  = 1'b1;
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    mc_mode  = 1'b0;
    state_in = '0;
    mc_expect("mc_dec", DEC_COL);

    // Reset during MixColumns byte 7 and during a key computation.
    key_in    = KEY;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    state_in  = ENC_IN;
    mc_mode   = 1'b0;
    mc_start  = 1'b1;
    tick();
    mc_start  = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    tick();
    chk("rst_pre_addr", 128'(mc_addr), 128'd7);
    chk("rst_pre_valid", 128'(mc_valid), 128'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_mc_valid", 128'(mc_valid), 128'd0);
      chk("post_rst_key_valid", 128'(key_valid), 128'd0);
      chk("post_rst_done", 128'(mc_done), 128'd0);
    end

    // Fresh start after reset, with key and MixColumns paths running together.
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    chk("restart_key_valid", 128'(key_valid), 128'd1);
    chk("restart_key_value", key_out, rev_bytes(KEY));
    key_req  = 1'b1;
    mc_start = 1'b1;
    tick();
    key_req  = 1'b0;
    mc_start = 1'b0;
    mc_expect("mc_restart", ENC_COL);
    chk("restart_key_round", 128'(key_round), 128'd1);
    chk("restart_key_round1", key_out, rev_bytes(RK1_BE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes128_round_ops.md
AES128_ROUND_OPS -- requirements
Module: aes128_round_ops

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; the clock port is clk_i and the reset port is rst_i.
REQ-002 Ports, in order: clk_i in 1 clock; rst_i in 1 sync active-high reset.
REQ-003 Ports: state_i in 128 AES state, byte n at [8n+7:8n], row = n%4, column = n/4; shift_rows_o out 128 ShiftRows(state_i).
REQ-004 Ports: mc_start_i in 1 MixColumns start pulse; mc_mode_i in 1 (0 = encrypt/MixColumns, 1 = decrypt/InvMixColumns).
REQ-005 Ports: mc_data_o out 8 result byte; mc_addr_o out 4 byte index; mc_valid_o out 1 byte strobe; mc_done_o out 1 last-byte flag.
REQ-006 Ports: key_i in 128 cipher key, big-endian (key byte 0 = [127:120]); key_start_i in 1 load key; key_req_i in 1 next-round-key request pulse.
REQ-007 Ports: key_o out 128 current round key in state byte order (key byte 0 at [7:0]); key_valid_o out 1 round-key strobe; key_round_o out 4 index of key on key_o.

Function
REQ-008 shift_rows_o SHALL be combinational: out byte (r,c) = state_i byte (r,(c+r) mod 4).
REQ-009 On mc_start_i, the block SHALL snapshot state_i and mc_mode_i; later changes to state_i SHALL NOT affect the result.
REQ-010 After start at cycle t, the block SHALL emit bytes 0..15 in order, one per cycle, with mc_valid_o high on cycles t+1..t+16.
REQ-011 mc_done_o SHALL pulse high on cycle t+16, together with the byte-15 strobe, and SHALL be low at all other times.
REQ-012 Encrypt SHALL use the GF(2^8) matrix rows {02 03 01 01} rotated; decrypt SHALL use {0e 0b 0d 09} rotated; reduction polynomial 0x11B.
REQ-013 mc_start_i during an active MixColumns SHALL abort it and restart with a fresh snapshot.
REQ-014 mc_data_o and mc_addr_o SHALL be 0 whenever mc_valid_o is low.
REQ-015 On key_start_i, the block SHALL capture key_i, set the round to 0, and pulse key_valid_o on the next cycle with key_o = byte-reversed key_i and key_round_o = 0.
REQ-016 On key_req_i at cycle t (round < 10), the block SHALL compute the next key using one shared S-box, one SubWord byte per cycle.
REQ-017 The next-key computation SHALL apply RotWord, SubWord and Rcon, then the XOR chain; it SHALL pulse key_valid_o at t+5 with the round incremented.
REQ-018 Rcon for rounds 1..10 SHALL be 01 02 04 08 10 20 40 80 1B 36.
REQ-019 key_o and key_round_o SHALL hold their values between strobes; key_valid_o SHALL be a single-cycle pulse.
REQ-020 key_req_i when round = 10, or while a computation is in progress, SHALL be ignored.
REQ-021 key_start_i SHALL take priority over key_req_i and over any in-progress computation.
REQ-022 The MixColumns and key paths SHALL operate independently and concurrently.

Reset
REQ-023 While rst_i is high, all outputs except shift_rows_o SHALL be 0 and both sequencers SHALL be idle, including when reset is applied mid-operation.
REQ-024 shift_rows_o SHALL track state_i regardless of reset.

Structure
REQ-025 A shared package SHALL hold: mode_t (ENCRYPT = 0, DECRYPT = 1), the S-box table, the Rcon table, the xtime/gf_mul functions and the byte-reverse function.
REQ-026 The key path SHALL be a sub-module named aes128_key_sched; MixColumns and ShiftRows SHALL be in the top level.

Verification
REQ-027 Apply key 2b7e151628aed2a6abf7158809cf4f3c with key_start_i -> next cycle key_valid_o = 1, key_round_o = 0, key_o = byte-reverse of key_i.
REQ-028 Then issue 10 key_req_i -> round 1 key = byte-reverse(a0fafe1788542cb123a339392a6c7605), round 10 key = byte-reverse(d014f9a8c9ee2589e13f0cc8b6630ca6), each key_valid_o exactly 5 cycles after its request; an 11th request -> no strobe.
REQ-029 Encrypt MixColumns on state with every column = db,13,53,45 (row 0..3) -> each column 8e,4d,a1,bc; addr 0..15 on cycles t+1..t+16; mc_done_o only at t+16.
REQ-030 Decrypt MixColumns on state with every column = 8e,4d,a1,bc -> each column db,13,53,45.
REQ-031 ShiftRows on state_i bytes 00..0f (byte n = n) -> shift_rows_o bytes 00,05,0a,0f,04,09,0e,03,08,0d,02,07,0c,01,06,0b.
REQ-032 Assert rst_i at byte 7 of a MixColumns run and mid key computation -> outputs 0 on the following cycle, no further strobes; a new start then completes normally.
